// File: rtl/multiply_acc_pkg.sv
// Shared types and sizing helpers for the multiply-accumulate vector block.
package multiply_acc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } acc_state_e;

  // Full-precision width of a sum of `lanes` signed values of `in_w` bits.
  function automatic int sum_width(input int in_w, input int lanes);
    return in_w + $clog2(lanes);
  endfunction

  // Smallest accumulator that holds one full-precision beat plus headroom.
  function automatic int min_acc_width(input int img_w, input int ker_w, input int lanes);
    return img_w + ker_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/sum_tree.sv
// Registered full-precision signed sum of LANES packed products.
module sum_tree
  import multiply_acc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      en_i,
  input  logic [LANES*IN_W-1:0]                     prod_i,
  output logic signed [sum_width(IN_W, LANES)-1:0]  sum_o
);

  localparam int OUT_W = sum_width(IN_W, LANES);

  logic signed [OUT_W-1:0] sum_d, sum_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + OUT_W'($signed(prod_i[i*IN_W +: IN_W]));
    end
  end

  // NOTE: state uses non-blocking '<=' under an async active-low reset so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/multiply_acc_vec.sv
// Four-stage signed dot-product accumulator with framed results and backpressure.
// Build option: define MULTIPLY_ACC_SATURATE_EN to clamp on overflow and report ovf.
module multiply_acc_vec
  import multiply_acc_pkg::*;
#(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES*IMG_WIDTH-1:0]   img,
  input  logic [LANES*KER_WIDTH-1:0]   ker,
  input  logic                         val,
  input  logic                         last,
  output logic                         rdy,
  output logic [ACC_WIDTH-1:0]         result,
  output logic                         result_val,
  input  logic                         result_rdy,
  output logic                         ovf
);

  localparam int PROD_W = IMG_WIDTH + KER_WIDTH;
  localparam int SUM_W  = sum_width(PROD_W, LANES);

  if (ACC_WIDTH < min_acc_width(IMG_WIDTH, KER_WIDTH, LANES)) begin : g_bad_acc_width
    $error("ACC_WIDTH too small for IMG_WIDTH, KER_WIDTH and LANES");
  end

  logic                         s1_val_q, s1_last_q;
  logic [LANES*IMG_WIDTH-1:0]   s1_img_q;
  logic [LANES*KER_WIDTH-1:0]   s1_ker_q;
  logic                         s2_val_q, s2_last_q;
  logic [LANES*PROD_W-1:0]      s2_prod_d, s2_prod_q;
  logic                         s3_val_q, s3_last_q;
  logic signed [SUM_W-1:0]      s3_sum;

  acc_state_e                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_next, base, lane_ext;
  logic signed [ACC_WIDTH-1:0]  result_q, result_d;
  logic                         result_val_q, result_val_d;
  logic                         s4_beat;

  // A held result blocks the whole pipeline, so every stage shares one enable.
  assign rdy     = !(result_val_q && !result_rdy);
  assign s4_beat = s3_val_q && rdy;

  always_comb begin
    s2_prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_prod_d[i*PROD_W +: PROD_W] =
        PROD_W'($signed(s1_img_q[i*IMG_WIDTH +: IMG_WIDTH])) *
        PROD_W'($signed(s1_ker_q[i*KER_WIDTH +: KER_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_img_q  <= '0;
      s1_ker_q  <= '0;
      s2_val_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_prod_q <= '0;
      s3_val_q  <= 1'b0;
      s3_last_q <= 1'b0;
    end else if (rdy) begin
      s1_val_q  <= val;
      s1_last_q <= val && last;
      s1_img_q  <= img;
      s1_ker_q  <= ker;
      s2_val_q  <= s1_val_q;
      s2_last_q <= s1_last_q;
      s2_prod_q <= s2_prod_d;
      s3_val_q  <= s2_val_q;
      s3_last_q <= s2_last_q;
    end
  end

  sum_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W)
  ) u_sum_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (rdy),
    .prod_i (s2_prod_q),
    .sum_o  (s3_sum)
  );

  // An empty accumulator adds to zero, which is the same as loading the lane sum.
  assign lane_ext = ACC_WIDTH'(s3_sum);
  assign base     = (state_q == BUSY) ? acc_q : '0;

`ifdef MULTIPLY_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide;
  logic                      beat_ovf, ovf_next, ovf_acc_q, ovf_q;

  always_comb begin
    wide     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(lane_ext);
    beat_ovf = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    acc_next = beat_ovf ? (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : wide[ACC_WIDTH-1:0];
    ovf_next = beat_ovf || (state_q == BUSY && ovf_acc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (s4_beat) begin
      if (s3_last_q) begin
        ovf_q     <= ovf_next;
        ovf_acc_q <= 1'b0;
      end else begin
        ovf_acc_q <= ovf_next;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign acc_next = base + lane_ext;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (s4_beat) begin
      state_d = s3_last_q ? EMPTY : BUSY;
    end
  end

  always_comb begin
    acc_d        = acc_q;
    result_d     = result_q;
    result_val_d = result_val_q && !result_rdy;
    if (s4_beat) begin
      if (s3_last_q) begin
        result_d     = acc_next;
        result_val_d = 1'b1;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      result_q     <= '0;
      result_val_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      result_q     <= result_d;
      result_val_q <= result_val_d;
    end
  end

  assign result     = result_q;
  assign result_val = result_val_q;

endmodule

// File: tb/tb_multiply_acc_vec.sv
// Directed self-checking bench: default 4-lane instance plus a 1-lane, 33-bit instance for overflow.
module tb_multiply_acc_vec;

  localparam int IW   = 16;
  localparam int KW   = 16;
  localparam int L    = 4;
  localparam int AW   = 40;
  localparam int AW_S = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [L*IW-1:0] img;
  logic [L*KW-1:0] ker;
  logic            val, last, rdy, result_val, result_rdy, ovf;
  logic [AW-1:0]   result;

  logic [IW-1:0]   img_s;
  logic [KW-1:0]   ker_s;
  logic            val_s, last_s, rdy_s, result_val_s, result_rdy_s, ovf_s;
  logic [AW_S-1:0] result_s;

  multiply_acc_vec #(.IMG_WIDTH(IW), .KER_WIDTH(KW), .LANES(L), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .img(img), .ker(ker), .val(val), .last(last), .rdy(rdy),
    .result(result), .result_val(result_val), .result_rdy(result_rdy), .ovf(ovf)
  );

  multiply_acc_vec #(.IMG_WIDTH(IW), .KER_WIDTH(KW), .LANES(1), .ACC_WIDTH(AW_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .img(img_s), .ker(ker_s), .val(val_s), .last(last_s), .rdy(rdy_s),
    .result(result_s), .result_val(result_val_s), .result_rdy(result_rdy_s), .ovf(ovf_s)
  );

  typedef struct packed {
    logic [63:0]        im;
    logic [63:0]        kr;
    logic signed [63:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic signed [63:0] got_q[$];
  int                 got_cyc[$];
  logic signed [63:0] got_s_q[$];
  logic               got_s_ovf[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && result_val && result_rdy) begin
      got_q.push_back($signed(result));
      got_cyc.push_back(cyc);
    end
    if (rst_n && result_val_s && result_rdy_s) begin
      got_s_q.push_back($signed(result_s));
      got_s_ovf.push_back(ovf_s);
    end
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic signed [63:0] q_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 'x;
  endfunction

  task automatic send(input logic [63:0] i, input logic [63:0] k, input logic l);
    int n = 0;
    logic ok = 1'b0;
    img = i; ker = k; last = l; val = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rdy === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) check("send_accept_timeout", 0, 1);
    @(posedge clk); #1;
    val = 1'b0; last = 1'b0;
  endtask

  task automatic send_s(input logic [15:0] i, input logic [15:0] k, input logic l);
    int n = 0;
    logic ok = 1'b0;
    img_s = i; ker_s = k; last_s = l; val_s = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rdy_s === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) check("send_s_accept_timeout", 0, 1);
    @(posedge clk); #1;
    val_s = 1'b0; last_s = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic wait_results_s(input int n, input int budget);
    int c = 0;
    while (got_s_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d, expected 0", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic signed [63:0] exp_sat;
    logic               exp_ovf;
    int                 c;

    vecs[0] = '{im: pack4(1, 2, 3, 4),                   kr: pack4(5, 6, 7, 8),                   exp: 64'sd70};
    vecs[1] = '{im: pack4(-1, -2, -3, -4),               kr: pack4(5, 6, 7, 8),                   exp: -64'sd70};
    vecs[2] = '{im: pack4(-32768, -32768, -32768, -32768), kr: pack4(-32768, -32768, -32768, -32768), exp: 64'sd4294967296};
    vecs[3] = '{im: pack4(32767, 32767, 32767, 32767),   kr: pack4(-32768, -32768, -32768, -32768), exp: -64'sd4294836224};
    vecs[4] = '{im: pack4(100, -200, 300, -400),         kr: pack4(3, 3, 3, 3),                   exp: -64'sd600};
    vecs[5] = '{im: pack4(0, 0, 0, 0),                   kr: pack4(1234, 1234, 1234, 1234),       exp: 64'sd0};

`ifdef MULTIPLY_ACC_SATURATE_EN
    exp_sat = 64'sd4294967295;
    exp_ovf = 1'b1;
`else
    exp_sat = -64'sd3221553147;
    exp_ovf = 1'b0;
`endif

    img = '0; ker = '0; val = 1'b0; last = 1'b0; result_rdy = 1'b1;
    img_s = '0; ker_s = '0; val_s = 1'b0; last_s = 1'b0; result_rdy_s = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_result_val", result_val, 0);
    check("reset_result", $signed(result), 0);
    check("reset_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_reset", rdy, 1);

    // Single-beat frame: latency of three edges after acceptance
    got_q.delete();
    send(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
    @(posedge clk); #1;
    check("lat_edge1_result_val", result_val, 0);
    @(posedge clk); #1;
    check("lat_edge2_result_val", result_val, 0);
    @(posedge clk); #1;
    check("lat_edge3_result_val", result_val, 1);
    check("single_beat_result", $signed(result), 10);
    check("single_beat_ovf", ovf, 0);
    repeat (4) @(posedge clk);
    #1;
    check("single_beat_count", got_q.size(), 1);

    // Three-beat frame with negative weights
    got_q.delete();
    send(pack4(2, 2, 2, 2), pack4(-3, -3, -3, -3), 1'b0);
    send(pack4(2, 2, 2, 2), pack4(-3, -3, -3, -3), 1'b0);
    send(pack4(2, 2, 2, 2), pack4(-3, -3, -3, -3), 1'b1);
    wait_results(1, 20);
    repeat (5) @(posedge clk);
    #1;
    check("three_beat_count", got_q.size(), 1);
    check("three_beat_result", q_at(0), -64'sd72);

    // Downstream stall with a second frame already in the pipeline
    got_q.delete();
    result_rdy = 1'b0;
    send(pack4(5, 0, 0, 0), pack4(3, 0, 0, 0), 1'b1);
    send(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0);
    send(pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), 1'b1);
    c = 0;
    while (result_val !== 1'b1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    check("stall_result_val", result_val, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_rdy_low", rdy, 0);
      check("stall_result_stable", $signed(result), 15);
      @(posedge clk); #1;
    end
    result_rdy = 1'b1;
    wait_results(2, 20);
    repeat (5) @(posedge clk);
    #1;
    check("stall_count", got_q.size(), 2);
    check("stall_first", q_at(0), 15);
    check("stall_second", q_at(1), 28);

    // Reset in the middle of a frame
    got_q.delete();
    send(pack4(100, 100, 100, 100), pack4(50, 50, 50, 50), 1'b0);
    send(pack4(100, 100, 100, 100), pack4(50, 50, 50, 50), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_result_val", result_val, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_rdy", rdy, 1);
    send(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1);
    wait_results(1, 20);
    repeat (6) @(posedge clk);
    #1;
    check("midreset_count", got_q.size(), 1);
    check("midreset_result", q_at(0), 7);

    // Back-to-back single-beat frames from the vector table
    got_q.delete();
    got_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].im, vecs[i].kr, 1'b1);
    end
    wait_results(6, 20);
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_result_%0d", i), q_at(i), vecs[i].exp);
    end
    for (int i = 1; i < 6; i++) begin
      if (i < got_cyc.size()) check($sformatf("stream_spacing_%0d", i), got_cyc[i] - got_cyc[i-1], 1);
    end

    // Overflow on the narrow 1-lane accumulator: 5 x 32767^2 exceeds 2^32-1
    got_s_q.delete();
    got_s_ovf.delete();
    for (int b = 0; b < 5; b++) begin
      send_s(16'sd32767, 16'sd32767, b == 4);
    end
    wait_results_s(1, 20);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_count", got_s_q.size(), 1);
    check("ovf_result", (got_s_q.size() > 0) ? got_s_q[0] : 'x, exp_sat);
    check("ovf_flag", (got_s_ovf.size() > 0) ? got_s_ovf[0] : 1'bx, exp_ovf);
    send_s(16'sd3, 16'sd4, 1'b1);
    wait_results_s(2, 20);
    #1;
    check("ovf_next_frame_result", (got_s_q.size() > 1) ? got_s_q[1] : 'x, 12);
    check("ovf_next_frame_flag", (got_s_ovf.size() > 1) ? got_s_ovf[1] : 1'bx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiply_acc_vec.md
MULTIPLY_ACC_VEC -- requirements
Module: multiply_acc_vec

Interface
REQ-001 The block SHALL use the parameter IMG_WIDTH, default 16, as the signed two's-complement width of each image sample.
REQ-002 The block SHALL use the parameter KER_WIDTH, default 16, as the signed two's-complement width of each kernel weight.
REQ-003 The block SHALL use the parameter LANES, default 4, as the number of parallel multiply lanes; legal values are 1 and above, and non-powers of two are allowed.
REQ-004 The block SHALL use the parameter ACC_WIDTH, default 40, as the accumulator and result width, which must be at least IMG_WIDTH+KER_WIDTH+clog2(LANES)+1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port img, input, LANES*IMG_WIDTH bits: image samples, with lane i at bits [i*IMG_WIDTH +: IMG_WIDTH].
REQ-008 The block SHALL have port ker, input, LANES*KER_WIDTH bits: kernel weights, packed the same way as img.
REQ-009 The block SHALL have port val, input, 1 bit: the input beat is valid.
REQ-010 The block SHALL have port last, input, 1 bit: the current beat closes the accumulation frame; it is sampled only with val.
REQ-011 The block SHALL have port rdy, output, 1 bit: the block can accept a beat.
REQ-012 The block SHALL have port result, output, ACC_WIDTH bits: the signed frame sum.
REQ-013 The block SHALL have port result_val, output, 1 bit: result is valid.
REQ-014 The block SHALL have port result_rdy, input, 1 bit: downstream accepts result.
REQ-015 The block SHALL have port ovf, output, 1 bit: the frame saturated, valid together with result_val.

Function
REQ-016 A beat SHALL be accepted on any rising edge where val and rdy are both high.
REQ-017 The datapath SHALL be a 4-stage pipeline: S1 registers inputs, S2 forms LANES signed products, S3 sums the products to full precision, and S4 accumulates.
REQ-018 rdy SHALL equal NOT(result_val AND NOT result_rdy), and when rdy is low all pipeline stages SHALL hold.
REQ-019 The accumulator SHALL have two states, EMPTY and BUSY; the reset state is EMPTY.
REQ-020 In EMPTY, an S4 beat SHALL load its lane sum into the accumulator and move the state to BUSY.
REQ-021 In BUSY, an S4 beat SHALL add its lane sum to the accumulator.
REQ-022 An S4 beat carrying last SHALL write the final sum to result, set result_val, and return the state to EMPTY.
REQ-023 A single-beat frame (last set on the first beat) SHALL produce result equal to that beat's lane sum.
REQ-024 With no stalls, result_val SHALL rise on the 3rd rising edge after the edge that accepted the last beat.
REQ-025 Back-to-back frames SHALL sustain one beat per cycle while result_rdy is high.
REQ-026 result_val SHALL clear on the edge where result_rdy is high, unless a new last beat completes on that same edge, in which case result_val stays high with the new result.
REQ-027 result and ovf SHALL remain stable while result_val is high and result_rdy is low.
REQ-028 Pipeline bubbles (edges with no accepted beat) SHALL NOT alter the accumulator or the state.
REQ-029 All arithmetic SHALL be signed, and products and lane sums SHALL be sign-extended to ACC_WIDTH before accumulation.

Reset
REQ-030 Asserting rst_n low SHALL, asynchronously, clear all pipeline registers, the accumulator, result, result_val and ovf to 0 and set the state to EMPTY.
REQ-031 A reset mid-frame or mid-pipeline SHALL discard all partial data, and no result_val SHALL be emitted for that frame.
REQ-032 rdy SHALL be high from the first edge after rst_n is released.

Configuration
REQ-033 With macro MULTIPLY_ACC_SATURATE_EN defined, the accumulator SHALL clamp to the signed ACC_WIDTH maximum or minimum on overflow, and ovf SHALL be set sticky for the frame and reported with result.
REQ-034 With MULTIPLY_ACC_SATURATE_EN undefined, the accumulator SHALL wrap modulo 2^ACC_WIDTH, and ovf SHALL be tied to 0.

Structure
REQ-035 Package multiply_acc_pkg SHALL hold the accumulator state enum (EMPTY, BUSY) and the minimum-ACC_WIDTH calculation as a constant function.
REQ-036 The S3 product summation SHALL be a sub-module named sum_tree, parameterised by LANES and input width, and registered at its output.

Verification
REQ-037 LANES=4, img={1,2,3,4}, ker={1,1,1,1}, one beat with last set -> result=10, result_val high 3 edges after acceptance, ovf=0.
REQ-038 Three beats with img lanes all 2 and ker lanes all -3, last on the 3rd beat -> result=-72, a single result_val pulse.
REQ-039 result_rdy held low for 5 cycles with a frame completed -> rdy low, result stable for those 5 cycles; releasing result_rdy -> the next frame proceeds with no lost or duplicated beats.
REQ-040 rst_n pulsed low after 2 beats of a 4-beat frame, then a fresh 1-beat frame of value 7 -> exactly one result, equal to 7.
REQ-041 ACC_WIDTH=33, max-positive operands repeated until overflow -> with MULTIPLY_ACC_SATURATE_EN, result=2^32-1 and ovf=1; without it, the wrapped value and ovf=0.
REQ-042 Continuous 1-beat frames with result_rdy high -> one result per cycle, each matching a reference model.
